// File: rtl/demux4way1_reg_if.sv
// Handshake bundle for the registered 1-to-4 demux: one producer port,
// four consumer lanes, plus per-lane delivery counters and a busy flag.
interface demux4way1_reg_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_sel;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
   logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
   logic             busy;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_c, out_d,
             cnt_a, cnt_b, cnt_c, cnt_d, busy
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_a, out_b, out_c, out_d,
             cnt_a, cnt_b, cnt_c, cnt_d, busy
   );
endinterface

// File: rtl/demux4way1_reg.sv
// Registered 1-to-4 demultiplexer: one holding register routes each word to
// lane hold_sel with valid/ready on every port; per-lane wrapping counters.
module demux4way1_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   demux4way1_reg_if.slave   bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                      state_q, state_d;
   logic [WIDTH-1:0]            hold_data;
   logic [1:0]                  hold_sel;
   logic                        deliver, accept, rdy;
   logic [3:0]                  lane_vld;
   logic [3:0][WIDTH-1:0]       lane_data;
   logic [3:0][CNT_W-1:0]       cnt_q;

   // Ready looks through to the selected consumer so a full slot can
   // drain and refill on the same edge (one word per cycle).
   assign deliver = (state_q == FULL) && bus.out_ready[hold_sel];
   assign rdy     = (state_q == EMPTY) || bus.out_ready[hold_sel];
   assign accept  = bus.in_valid && rdy;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (bus.in_valid) state_d = FULL;
         FULL:    if (deliver && !bus.in_valid) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= EMPTY;
         hold_data <= '0;
         hold_sel  <= 2'b00;
      end else begin
         state_q <= state_d;
         if (accept) begin
            hold_data <= bus.in_data;
            hold_sel  <= bus.in_sel;
         end
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign lane_vld[k]  = (state_q == FULL) && (hold_sel == 2'(k));
      assign lane_data[k] = lane_vld[k] ? hold_data : '0;

      always_ff @(posedge clk) begin
         if (reset)
            cnt_q[k] <= '0;
         else if (deliver && (hold_sel == 2'(k)))
            cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = lane_vld;
   assign bus.out_a     = lane_data[0];
   assign bus.out_b     = lane_data[1];
   assign bus.out_c     = lane_data[2];
   assign bus.out_d     = lane_data[3];
   assign bus.cnt_a     = cnt_q[0];
   assign bus.cnt_b     = cnt_q[1];
   assign bus.cnt_c     = cnt_q[2];
   assign bus.cnt_d     = cnt_q[3];
   assign bus.busy      = (state_q == FULL);
endmodule

// File: tb/tb_demux4way1_reg.sv
// Bench for demux4way1_reg: directed scenarios plus random traffic against a
// one-deep queue model with modulo-4 lane counters (CNT_W = 2).
module tb_demux4way1_reg;
   localparam int W  = 32;
   localparam int CW = 2;

   typedef logic [W+1:0] item_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   demux4way1_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   demux4way1_reg #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [3:0][W-1:0]  lanes;
   logic [3:0][CW-1:0] cnts;
   assign lanes = {bus.out_d, bus.out_c, bus.out_b, bus.out_a};
   assign cnts  = {bus.cnt_d, bus.cnt_c, bus.cnt_b, bus.cnt_a};

   // Model: a single-slot FIFO and four delivery tallies.
   item_t mq[$];
   int    mcnt[4];

   function automatic logic [3:0] exp_vld();
      if (mq.size() == 0) return 4'b0000;
      return 4'b0001 << mq[0][W+1:W];
   endfunction

   function automatic logic [W-1:0] exp_lane(int k);
      if (mq.size() == 0 || int'(mq[0][W+1:W]) != k) return '0;
      return mq[0][W-1:0];
   endfunction

   function automatic logic exp_ready();
      return (mq.size() == 0) || bus.out_ready[mq[0][W+1:W]];
   endfunction

   task automatic tick();
      bit pop;
      int s;
      if (reset) begin
         mq.delete();
         for (int k = 0; k < 4; k++) mcnt[k] = 0;
      end else begin
         pop = (mq.size() > 0) && bus.out_ready[mq[0][W+1:W]];
         if (pop) begin
            s = int'(mq[0][W+1:W]);
            mcnt[s] = (mcnt[s] + 1) % 4;
            void'(mq.pop_front());
         end
         if (bus.in_valid && mq.size() == 0) mq.push_back({bus.in_sel, bus.in_data});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      n_chk++;
      if ({bus.out_valid, bus.busy, bus.in_ready} !== 6'b000001) begin
         n_fail++;
         $display("FAIL reset_ctl: got vld=%b busy=%b rdy=%b, want 0000/0/1", bus.out_valid, bus.busy, bus.in_ready);
      end
      n_chk++;
      if (lanes !== '0 || cnts !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got lanes=%h cnts=%h, want all zero", lanes, cnts);
      end
   endtask

   task automatic test_basic();
      do_reset();
      bus.out_ready = 4'b1111;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hDEADBEEF;
      bus.in_sel    = 2'b10;
      tick();
      bus.in_valid = 1'b0;
      #1;
      n_chk++;
      if (bus.out_valid !== 4'b0100 || bus.out_c !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL basic_lane_c: got vld=%b c=%h, want 0100 deadbeef", bus.out_valid, bus.out_c);
      end
      n_chk++;
      if ((bus.out_a | bus.out_b | bus.out_d) !== '0) begin
         n_fail++;
         $display("FAIL basic_other_lanes: got a=%h b=%h d=%h, want 0", bus.out_a, bus.out_b, bus.out_d);
      end
      tick();
      n_chk++;
      if (bus.cnt_c !== 2'd1 || bus.out_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL basic_cnt_c: got cnt_c=%0d vld=%b, want 1 0000", bus.cnt_c, bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_sel   = 2'(i);
         bus.in_data  = W'(i + 1);
         #1;
         n_chk++;
         if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready[%0d]: got %b, want 1", i, bus.in_ready);
         end
         tick();
         n_chk++;
         if (bus.out_valid !== (4'b0001 << i) || lanes[i] !== W'(i + 1)) begin
            n_fail++;
            $display("FAIL b2b_lane[%0d]: got vld=%b data=%h, want %b %h", i, bus.out_valid, lanes[i], 4'b0001 << i, i + 1);
         end
      end
      bus.in_valid = 1'b0;
      tick();
      n_chk++;
      if (cnts !== {2'd1, 2'd1, 2'd1, 2'd1}) begin
         n_fail++;
         $display("FAIL b2b_counts: got %h, want 55", cnts);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.out_ready = 4'b1111;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'b01;
      bus.in_data   = 32'h55;
      tick();
      bus.out_ready = 4'b1101;
      for (int i = 0; i < 5; i++) begin
         bus.in_data = $urandom;
         bus.in_sel  = 2'($urandom_range(0, 3));
         #1;
         n_chk++;
         if (bus.out_b !== 32'h55 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got b=%h rdy=%b busy=%b vld=%b, want 55 0 1 0010", i, bus.out_b, bus.in_ready, bus.busy, bus.out_valid);
         end
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 4'b1111;
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_ready: got %b, want 1", bus.in_ready);
      end
      tick();
      tick();
      n_chk++;
      if (bus.cnt_b !== 2'd1 || bus.out_valid !== 4'b0000 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_delivered_once: got cnt_b=%0d vld=%b busy=%b, want 1 0000 0", bus.cnt_b, bus.out_valid, bus.busy);
      end
   endtask

   task automatic test_nonsel_ready();
      do_reset();
      bus.out_ready = 4'b1111;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'b11;
      bus.in_data   = 32'hA5A5_0003;
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++;
         if (bus.out_valid !== 4'b1000 || bus.cnt_d !== 2'd0 || bus.out_d !== 32'hA5A5_0003) begin
            n_fail++;
            $display("FAIL nonsel_hold[%0d]: got vld=%b cnt_d=%0d d=%h, want 1000 0 a5a50003", i, bus.out_valid, bus.cnt_d, bus.out_d);
         end
         tick();
      end
      bus.out_ready = 4'b1000;
      tick();
      n_chk++;
      if (bus.cnt_d !== 2'd1 || bus.out_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL nonsel_release: got cnt_d=%0d vld=%b, want 1 0000", bus.cnt_d, bus.out_valid);
      end
   endtask

   task automatic test_wrap();
      logic [CW-1:0] seq [5];
      seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      bus.out_ready = 4'b1111;
      bus.in_sel    = 2'b00;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = (i < 5);
         bus.in_data  = W'(i);
         tick();
         if (i >= 1) begin
            n_chk++;
            if (bus.cnt_a !== seq[i-1]) begin
               n_fail++;
               $display("FAIL wrap_cnt_a[%0d]: got %0d, want %0d", i - 1, bus.cnt_a, seq[i-1]);
            end
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.out_ready = 4'b1111;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'b00;
      bus.in_data   = 32'h11;
      tick();
      bus.in_sel  = 2'b10;
      bus.in_data = 32'h22;
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 4'b0000;
      tick();
      n_chk++;
      if (bus.busy !== 1'b1 || bus.cnt_a !== 2'd1 || bus.out_c !== 32'h22) begin
         n_fail++;
         $display("FAIL rmid_pre: got busy=%b cnt_a=%0d c=%h, want 1 1 22", bus.busy, bus.cnt_a, bus.out_c);
      end
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'b01;
      tick();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      n_chk++;
      if ({bus.out_valid, bus.busy, bus.in_ready} !== 6'b000001 || cnts !== '0 || lanes !== '0) begin
         n_fail++;
         $display("FAIL rmid_post: got vld=%b busy=%b rdy=%b cnts=%h lanes=%h, want 0000 0 1 0 0", bus.out_valid, bus.busy, bus.in_ready, cnts, lanes);
      end
      bus.out_ready = 4'b1111;
      tick();
      n_chk++;
      if (bus.cnt_c !== 2'd0 || bus.out_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL rmid_discard: got cnt_c=%0d vld=%b, want 0 0000", bus.cnt_c, bus.out_valid);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         reset         = ($urandom_range(0, 99) < 2);
         bus.in_valid  = ($urandom_range(0, 99) < 65);
         bus.in_data   = $urandom;
         bus.in_sel    = 2'($urandom_range(0, 3));
         bus.out_ready = 4'($urandom);
         #1;
         n_chk++;
         if (bus.out_valid !== exp_vld() || bus.busy !== (mq.size() > 0)) begin
            n_fail++;
            $display("FAIL rnd_valid c%0d: got vld=%b busy=%b, want %b %b", c, bus.out_valid, bus.busy, exp_vld(), mq.size() > 0);
         end
         n_chk++;
         if (bus.in_ready !== exp_ready()) begin
            n_fail++;
            $display("FAIL rnd_ready c%0d: got %b, want %b", c, bus.in_ready, exp_ready());
         end
         for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (lanes[k] !== exp_lane(k) || cnts[k] !== CW'(mcnt[k])) begin
               n_fail++;
               $display("FAIL rnd_lane%0d c%0d: got data=%h cnt=%0d, want %h %0d", k, c, lanes[k], cnts[k], exp_lane(k), mcnt[k]);
            end
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_sel    = 2'b00;
      bus.out_ready = 4'b0000;
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_nonsel_ready();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/demux4way1_reg.md
Name: demux4way1_reg

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshaking on every port; the inverse of the 4-way select mux.
- Takes one WIDTH-bit word plus a 2-bit select and delivers it to exactly one of four output lanes (00 → a, 01 → b, 10 → c, 11 → d).
- Sits in the write-back/datapath routing fabric wherever a single producer feeds four consumers.
- Keeps a wrapping per-lane count of delivered words for debug and performance visibility.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 8, width of each per-lane delivery counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination lane: 00 a, 01 b, 10 c, 11 d.
- out_valid  output  4  one-hot lane valid; bit0 = a, bit1 = b, bit2 = c, bit3 = d.
- out_ready  input  4  per-lane consumer ready, same bit order as out_valid.
- out_a, out_b, out_c, out_d  output  WIDTH each  lane data.
- cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W each  words delivered per lane.
- busy  output  1  high while a word is held (state FULL).

Behaviour:
- Storage: one holding register containing hold_data (WIDTH bits) and hold_sel (2 bits).
- State machine has two states, EMPTY and FULL:
  - EMPTY → FULL when in_valid is high (in_ready is 1 in EMPTY).
  - FULL → FULL when the held word is delivered and a new word is accepted in the same cycle.
  - FULL → EMPTY when the held word is delivered and in_valid is low.
  - FULL stays FULL with contents unchanged while out_ready[hold_sel] is 0.
- in_ready = (state == EMPTY) OR out_ready[hold_sel]. This is combinational from out_ready and allows back-to-back throughput of one word per cycle.
- Acceptance: when in_valid and in_ready are both high on an edge, in_data and in_sel are captured into the holding register.
- Delivery: in FULL, out_valid[hold_sel] = 1 and every other out_valid bit is 0. A word is delivered on an edge where out_valid[k] and out_ready[k] are both high.
- Data outputs: the selected lane drives hold_data. Unselected lanes and all lanes in EMPTY drive all zeros.
- Latency: a word accepted at edge N appears on its lane in the cycle after edge N, i.e. one cycle of latency.
- Ordering: words leave in acceptance order. No reordering, no drops, no duplication.
- Held contents are stable: hold_data and hold_sel do not change while a delivery is pending, whatever in_valid, in_data or in_sel do.
- out_ready bits on non-selected lanes are ignored.
- Counters:
  - cnt_k increments by 1 on every delivery to lane k.
  - It wraps from 2^CNT_W − 1 to 0 with no saturation.
  - At most one counter increments per cycle.
- busy = (state == FULL).
- Reset (synchronous, active-high), applied on the edge where reset is high:
  - state = EMPTY, hold_data = 0, hold_sel = 00, all counters = 0.
  - Resulting outputs: out_valid = 0000, all out_* = 0, busy = 0, in_ready = 1.
  - in_valid is ignored on a reset edge.
  - A word held at reset is discarded and is not counted.
- Reset has priority over a delivery or acceptance on the same edge.
- X on in_data or in_sel while in_valid is low must not propagate into state.

Test Plan:
- Reset, then in_valid = 1, in_data = 0xDEADBEEF, in_sel = 10, out_ready = 1111 → next cycle out_valid = 0100, out_c = 0xDEADBEEF, out_a = out_b = out_d = 0; cnt_c = 1 after the following edge.
- Back-to-back stream: sel 00, 01, 10, 11 with data 1, 2, 3, 4 and out_ready = 1111 → in_ready stays 1; lanes a..d each show their word on consecutive cycles; all counters end at 1.
- Backpressure: word 0x55 to lane b with out_ready[1] = 0 for 5 cycles while in_data toggles → out_b holds 0x55, in_ready = 0 and busy = 1 throughout; raising out_ready[1] delivers it exactly once and cnt_b = 1.
- Non-selected ready ignored: held word for lane d, out_ready = 0111 → no delivery and cnt_d unchanged until out_ready[3] rises.
- Counter wrap with CNT_W = 2: five deliveries to lane a → cnt_a sequence 1, 2, 3, 0, 1.
- Reset mid-operation: reset asserted while FULL with out_ready = 0 → next cycle out_valid = 0000, busy = 0, in_ready = 1, all counters = 0, held word never delivered.
